// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity-mode constants, receiver state encoding and parity helper
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   // data_xor is the XOR of all data bits; returns 1 when the received parity bit is wrong
   function automatic logic parity_error(input int mode, input logic data_xor, input logic par_bit);
      logic err;
      err = 1'b0;
      if (mode == PAR_EVEN) begin
         err = data_xor ^ par_bit;
      end else if (mode == PAR_ODD) begin
         err = ~(data_xor ^ par_bit);
      end
      return err;
   endfunction

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - first-word-fall-through receive FIFO with drop indication when full
module rx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
   assign do_push = push && (!full || do_pop);
   assign drop    = push && full && !do_pop;
   assign head    = empty ? '0 : mem[rd_ptr];

   // Storage array; only written on an accepted push, so no reset is needed
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with parity/framing checks feeding a receive FIFO
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ    = 50000000,
   parameter int BAUD        = 9600,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           RX_Port,
   input  logic                           Rd_En,
   input  logic                           Clr_Overrun,
   output logic [DATA_BITS-1:0]           Data_RX,
   output logic                           Parity_Error,
   output logic                           Framing_Error,
   output logic                           RX_Flag,
   output logic                           Full,
   output logic [$clog2(FIFO_DEPTH):0]    Count,
   output logic                           Overrun
);

   localparam int BIT_TICKS  = CLK_FREQ / BAUD;
   localparam int HALF_TICKS = BIT_TICKS / 2;
   localparam int CNT_W      = $clog2(BIT_TICKS);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
   localparam logic [3:0]       BITS_LAST = 4'(DATA_BITS - 1);

   rx_state_t              state;
   logic [CNT_W-1:0]       tick_cnt;
   logic [3:0]             bit_cnt;
   logic [DATA_BITS-1:0]   shreg;
   logic                   par_err;
   logic                   sync1;
   logic                   rx_s;
   logic                   rx_prev;
   logic                   fifo_push;
   logic [DATA_BITS+1:0]   fifo_wdata;
   logic [DATA_BITS+1:0]   fifo_head;
   logic                   fifo_empty;
   logic                   fifo_drop;

   // Two-flop synchronizer plus one delay stage for falling-edge detection; idles high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= RX_Port;
         rx_s    <= sync1;
         rx_prev <= rx_s;
      end
   end

   // Frame receiver: start validation at half bit, then one sample per bit period
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tick_cnt <= '0;
               if (rx_prev && !rx_s) begin
                  state <= START;
               end
            end
            START: begin
               if (tick_cnt == HALF_LAST) begin
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  par_err  <= 1'b0;
                  state    <= rx_s ? IDLE : DATA;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            DATA: begin
               if (tick_cnt == BIT_LAST) begin
                  tick_cnt <= '0;
                  shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == BITS_LAST) begin
                     state <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (tick_cnt == BIT_LAST) begin
                  tick_cnt <= '0;
                  par_err  <= parity_error(PARITY_MODE, ^shreg, rx_s);
                  state    <= STOP;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            STOP: begin
               if (tick_cnt == BIT_LAST) begin
                  tick_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               tick_cnt <= '0;
            end
         endcase
      end
   end

   // The word is written on the stop-bit sample cycle; a low stop bit marks a framing error
   assign fifo_push  = (state == STOP) && (tick_cnt == BIT_LAST);
   assign fifo_wdata = {shreg, par_err, ~rx_s};

   rx_fifo #(
      .WIDTH (DATA_BITS + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .pop       (Rd_En),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (Full),
      .count     (Count),
      .drop      (fifo_drop)
   );

   // Sticky overrun: a dropped word sets it, and wins over a simultaneous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Overrun <= 1'b0;
      end else if (fifo_drop) begin
         Overrun <= 1'b1;
      end else if (!Clr_Overrun) begin
         Overrun <= 1'b0;
      end
   end

   assign Data_RX       = fifo_head[DATA_BITS+1:2];
   assign Parity_Error  = fifo_head[1];
   assign Framing_Error = fifo_head[0];
   assign RX_Flag       = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed table-driven bench for uart_rx_fifo
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   localparam int CLK_FREQ = 1000000;
   localparam int BAUD     = 62500;
   localparam int BIT      = CLK_FREQ / BAUD;

   logic       clk;
   logic       reset;
   logic       RX_Port;
   logic       Rd_En;
   logic       Clr_Overrun;
   logic [7:0] Data_RX;
   logic       Parity_Error;
   logic       Framing_Error;
   logic       RX_Flag;
   logic       Full;
   logic [2:0] Count;
   logic       Overrun;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       s;
      logic       pe;
      logic       fe;
   } vec_t;

   vec_t vecs[7];

   uart_rx_fifo #(
      .CLK_FREQ    (CLK_FREQ),
      .BAUD        (BAUD),
      .DATA_BITS   (8),
      .PARITY_MODE (1),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .RX_Port       (RX_Port),
      .Rd_En         (Rd_En),
      .Clr_Overrun   (Clr_Overrun),
      .Data_RX       (Data_RX),
      .Parity_Error  (Parity_Error),
      .Framing_Error (Framing_Error),
      .RX_Flag       (RX_Flag),
      .Full          (Full),
      .Count         (Count),
      .Overrun       (Overrun)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      RX_Port = 1'b0;
      tick(BIT);
      for (int i = 0; i < 8; i++) begin
         RX_Port = d[i];
         tick(BIT);
      end
      RX_Port = p;
      tick(BIT);
      RX_Port = s;
      tick(BIT);
      RX_Port = 1'b1;
      tick(4);
   endtask

   task automatic pop();
      Rd_En = 1'b1;
      tick(1);
      Rd_En = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data"}, Data_RX, 0);
      chk({tag, "_pe"}, Parity_Error, 0);
      chk({tag, "_fe"}, Framing_Error, 0);
      chk({tag, "_flag"}, RX_Flag, 0);
      chk({tag, "_full"}, Full, 0);
      chk({tag, "_count"}, Count, 0);
      chk({tag, "_ovr"}, Overrun, 0);
   endtask

   task automatic pop_on_push();
      int n;
      n = 0;
      while (dut.fifo_push !== 1'b1 && n < 20 * BIT) begin
         @(negedge clk);
         n++;
      end
      chk("simul_push_seen", int'(n < 20 * BIT), 1);
      Rd_En = 1'b1;
      @(posedge clk);
      #1;
      Rd_En = 1'b0;
   endtask

   initial begin
      vecs[0] = '{d: 8'h49, p: 1'b1, s: 1'b1, pe: 1'b0, fe: 1'b0};
      vecs[1] = '{d: 8'h4E, p: 1'b1, s: 1'b1, pe: 1'b1, fe: 1'b0};
      vecs[2] = '{d: 8'h54, p: 1'b1, s: 1'b0, pe: 1'b0, fe: 1'b1};
      vecs[3] = '{d: 8'h00, p: 1'b0, s: 1'b1, pe: 1'b0, fe: 1'b0};
      vecs[4] = '{d: 8'hFF, p: 1'b0, s: 1'b1, pe: 1'b0, fe: 1'b0};
      vecs[5] = '{d: 8'hFF, p: 1'b1, s: 1'b1, pe: 1'b1, fe: 1'b0};
      vecs[6] = '{d: 8'h80, p: 1'b1, s: 1'b1, pe: 1'b0, fe: 1'b0};

      reset = 1'b0;
      RX_Port = 1'b1;
      Rd_En = 1'b0;
      Clr_Overrun = 1'b1;
      tick(3);
      chk_all_zero("reset");
      reset = 1'b1;
      tick(2 * BIT);

      for (int i = 0; i < 7; i++) begin
         send_frame(vecs[i].d, vecs[i].p, vecs[i].s);
         chk($sformatf("vec%0d_flag", i), RX_Flag, 1);
         chk($sformatf("vec%0d_count", i), Count, 1);
         chk($sformatf("vec%0d_data", i), Data_RX, vecs[i].d);
         chk($sformatf("vec%0d_pe", i), Parity_Error, vecs[i].pe);
         chk($sformatf("vec%0d_fe", i), Framing_Error, vecs[i].fe);
         pop();
         chk($sformatf("vec%0d_popped_flag", i), RX_Flag, 0);
         chk($sformatf("vec%0d_popped_data", i), Data_RX, 0);
         tick(BIT);
      end

      Rd_En = 1'b1;
      tick(2);
      Rd_En = 1'b0;
      chk("empty_pop_count", Count, 0);

      RX_Port = 1'b0;
      tick(3);
      RX_Port = 1'b1;
      tick(3 * BIT);
      chk("glitch_count", Count, 0);
      chk("glitch_flag", RX_Flag, 0);

      for (int i = 1; i <= 5; i++) begin
         logic [7:0] w;
         w = 8'(i * 17);
         send_frame(w, ^w, 1'b1);
      end
      chk("ovr_full", Full, 1);
      chk("ovr_count", Count, 4);
      chk("ovr_set", Overrun, 1);
      chk("ovr_head", Data_RX, 8'h11);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("ovr_pop%0d_data", i), Data_RX, i * 17);
         pop();
      end
      chk("ovr_drained_flag", RX_Flag, 0);
      chk("ovr_sticky", Overrun, 1);
      Clr_Overrun = 1'b0;
      tick(1);
      Clr_Overrun = 1'b1;
      chk("ovr_cleared", Overrun, 0);

      for (int i = 1; i <= 4; i++) begin
         logic [7:0] w;
         w = 8'(i);
         send_frame(w, ^w, 1'b1);
      end
      chk("simul_prefull", Full, 1);
      fork
         send_frame(8'h05, 1'b0, 1'b1);
         pop_on_push();
      join
      chk("simul_count", Count, 4);
      chk("simul_full", Full, 1);
      chk("simul_ovr", Overrun, 0);
      for (int i = 2; i <= 5; i++) begin
         chk($sformatf("simul_pop%0d_data", i), Data_RX, i);
         pop();
      end
      chk("simul_drained", RX_Flag, 0);

      send_frame(8'h33, 1'b0, 1'b1);
      chk("prereset_count", Count, 1);
      RX_Port = 1'b0;
      tick(BIT);
      RX_Port = 1'b1;
      tick(BIT);
      RX_Port = 1'b0;
      tick(BIT / 2);
      reset = 1'b0;
      #1;
      chk_all_zero("midreset");
      tick(3);
      RX_Port = 1'b1;
      tick(2);
      reset = 1'b1;
      tick(2 * BIT);
      chk("postreset_count", Count, 0);
      send_frame(8'h49, 1'b1, 1'b1);
      chk("postreset_flag", RX_Flag, 1);
      chk("postreset_count1", Count, 1);
      chk("postreset_data", Data_RX, 8'h49);
      chk("postreset_pe", Parity_Error, 0);
      chk("postreset_fe", Framing_Error, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
